// File: rtl/ladybird_bus_arbiter.sv
// Round-robin arbiter sharing one single-ported target between N_REQ masters, one transaction at a time.
// Optional response watchdog enabled by defining LADYBIRD_ARB_TIMEOUT_EN.
module ladybird_bus_arbiter #(
  parameter int N_REQ          = 2,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*XLEN-1:0]      req_addr,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*XLEN/8-1:0]    req_wstrb,
  input  logic [N_REQ*XLEN-1:0]      req_wdata,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [XLEN-1:0]            rsp_data,
  output logic                       rsp_err,
  output logic                       tgt_valid,
  input  logic                       tgt_ready,
  output logic [XLEN-1:0]            tgt_addr,
  output logic                       tgt_we,
  output logic [XLEN/8-1:0]          tgt_wstrb,
  output logic [XLEN-1:0]            tgt_wdata,
  input  logic                       tgt_rsp_valid,
  input  logic [XLEN-1:0]            tgt_rsp_data,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy
);

  localparam int OW = $clog2(N_REQ);
  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q;
  logic [OW-1:0]     owner_q, rr_ptr_q;
  logic              tgt_valid_q, busy_q, tgt_we_q;
  logic [XLEN-1:0]   tgt_addr_q, tgt_wdata_q;
  logic [SW-1:0]     tgt_wstrb_q;

  logic [XLEN-1:0]   addr_a  [N_REQ];
  logic [XLEN-1:0]   wdata_a [N_REQ];
  logic [SW-1:0]     wstrb_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*XLEN +: XLEN];
    assign wdata_a[g] = req_wdata[g*XLEN +: XLEN];
    assign wstrb_a[g] = req_wstrb[g*SW +: SW];
  end

  logic              win_found;
  logic [OW-1:0]     win_idx, scan_idx;
  logic [N_REQ-1:0]  owner_oh;

  // First pending request scanning upward from rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan_idx  = '0;
    owner_oh  = '0;
    owner_oh[owner_q] = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = OW'((int'(rr_ptr_q) + i) % N_REQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  logic timeout;

`ifdef LADYBIRD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] wait_cnt_q;

  // Cleared while in ISSUE so the first WAIT cycle always starts from zero.
  always_ff @(posedge clk) begin
    if (!nrst)                wait_cnt_q <= '0;
    else if (state_q == ISSUE) wait_cnt_q <= '0;
    else if (state_q == WAIT)  wait_cnt_q <= wait_cnt_q + CW'(1);
  end

  assign timeout = (state_q == WAIT) && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  logic complete;
  assign complete = ((state_q == ISSUE) && tgt_ready && tgt_rsp_valid) ||
                    ((state_q == WAIT) && (tgt_rsp_valid || timeout));

  assign req_ready = ((state_q == ISSUE) && tgt_ready) ? owner_oh : '0;
  assign rsp_valid = complete ? owner_oh : '0;
  assign rsp_err   = timeout && !tgt_rsp_valid;
  assign rsp_data  = rsp_err ? '0 : tgt_rsp_data;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!nrst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      tgt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      tgt_addr_q  <= '0;
      tgt_we_q    <= 1'b0;
      tgt_wstrb_q <= '0;
      tgt_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (win_found) begin
          tgt_addr_q  <= addr_a[win_idx];
          tgt_we_q    <= req_we[win_idx];
          tgt_wstrb_q <= wstrb_a[win_idx];
          tgt_wdata_q <= wdata_a[win_idx];
          owner_q     <= win_idx;
          tgt_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= ISSUE;
        end
        ISSUE: if (tgt_ready) begin
          tgt_valid_q <= 1'b0;
          if (tgt_rsp_valid) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: if (tgt_rsp_valid || timeout) begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          rr_ptr_q <= (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tgt_valid = tgt_valid_q;
  assign tgt_addr  = tgt_addr_q;
  assign tgt_we    = tgt_we_q;
  assign tgt_wstrb = tgt_wstrb_q;
  assign tgt_wdata = tgt_wdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: per-cycle vector table plus watchdog / stuck-WAIT sequence.
module tb_ladybird_bus_arbiter;

  localparam int N = 2;
  localparam int X = 32;
  localparam int TMO = 8;

  localparam logic [X-1:0] A0 = 32'h1000_0010;
  localparam logic [X-1:0] A1 = 32'h2000_0024;
  localparam logic [X-1:0] W0 = 32'hCAFE_0000;
  localparam logic [X-1:0] W1 = 32'hBEEF_0001;

  logic            clk = 1'b0;
  logic            nrst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*X-1:0]  req_addr, req_wdata;
  logic [N*X/8-1:0] req_wstrb;
  logic [X-1:0]    rsp_data, tgt_addr, tgt_wdata, tgt_rsp_data;
  logic            rsp_err, tgt_valid, tgt_ready, tgt_we, tgt_rsp_valid, busy;
  logic [X/8-1:0]  tgt_wstrb;
  logic [0:0]      owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ladybird_bus_arbiter #(.N_REQ(N), .XLEN(X), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_addr(tgt_addr), .tgt_we(tgt_we),
    .tgt_wstrb(tgt_wstrb), .tgt_wdata(tgt_wdata),
    .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_data(tgt_rsp_data),
    .owner(owner), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       nrst;
    logic [1:0] rv;
    logic       tr;
    logic       trv;
    logic [31:0] rdata;
    logic [1:0] e_rr;
    logic [1:0] e_rsv;
    logic       e_tv;
    logic       e_busy;
    logic       e_own;
    logic       e_err;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [29];

  task automatic drive(input logic n, input logic [1:0] rv, input logic tr, input logic trv,
                       input logic [31:0] rd);
    nrst = n; req_valid = rv; tgt_ready = tr; tgt_rsp_valid = trv; tgt_rsp_data = rd;
  endtask

  initial begin
    int hit;
    int stuck;
    logic [1:0]  hit_rsv;
    logic        hit_err;
    logic [31:0] hit_data;

    req_addr  = {A1, A0};
    req_wdata = {W1, W0};
    req_we    = 2'b01;
    req_wstrb = {4'hF, 4'b0011};
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0);

    //         nrst rv    tr   trv  rdata          rr     rsv    tv   busy own  err  addr
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, A0};
    vecs[3]  = '{1'b1, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, A0};
    vecs[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, A0};
    vecs[5]  = '{1'b1, 2'b00, 1'b0, 1'b1, 32'h1234_5678, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, A0};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, A0};
    vecs[7]  = '{1'b1, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, A0};
    vecs[9]  = '{1'b1, 2'b11, 1'b0, 1'b1, 32'hA5A5_0001, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, A0};
    vecs[10] = '{1'b1, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, A0};
    vecs[11] = '{1'b1, 2'b11, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, A1};
    vecs[12] = '{1'b1, 2'b11, 1'b0, 1'b1, 32'hA5A5_0002, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, A1};
    vecs[13] = '{1'b1, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, A1};
    vecs[14] = '{1'b1, 2'b11, 1'b1, 1'b1, 32'hA5A5_0003, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, A0};
    vecs[15] = '{1'b1, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, A0};
    vecs[16] = '{1'b1, 2'b11, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, A1};
    vecs[17] = '{1'b1, 2'b00, 1'b0, 1'b1, 32'hA5A5_0004, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, A1};
    vecs[18] = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, A1};
    vecs[19] = '{1'b1, 2'b10, 1'b0, 1'b1, 32'hDEAD_0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, A1};
    vecs[20] = '{1'b1, 2'b00, 1'b0, 1'b1, 32'hDEAD_0001, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, A1};
    vecs[21] = '{1'b1, 2'b00, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, A1};
    vecs[22] = '{1'b1, 2'b00, 1'b0, 1'b1, 32'hA5A5_0005, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, A1};
    vecs[23] = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, A1};
    vecs[24] = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, A1};
    vecs[25] = '{1'b1, 2'b00, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, A1};
    vecs[26] = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, A1};
    vecs[27] = '{1'b1, 2'b00, 1'b0, 1'b1, 32'hBAD0_BAD0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[28] = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    repeat (3) @(posedge clk);

    // Inputs change just after the rising edge; outputs are compared on the falling edge.
    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].nrst, vecs[i].rv, vecs[i].tr, vecs[i].trv, vecs[i].rdata);
      @(negedge clk);
      check($sformatf("vec%0d {rdy,rsv,tv,busy,own,err,addr}", i),
            64'({req_ready, rsp_valid, tgt_valid, busy, owner, rsp_err, tgt_addr}),
            64'({vecs[i].e_rr, vecs[i].e_rsv, vecs[i].e_tv, vecs[i].e_busy, vecs[i].e_own,
                 vecs[i].e_err, vecs[i].e_addr}));
      if (vecs[i].e_rsv != 2'b00)
        check($sformatf("vec%0d rsp_data", i), 64'(rsp_data), 64'(vecs[i].rdata));
    end

    // Watchdog sequence: master 0 issues a write, target accepts it and never answers.
    @(posedge clk); #1;
    drive(1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("issue latched we/wstrb/wdata", 64'({tgt_we, tgt_wstrb, tgt_wdata}),
          64'({1'b1, 4'b0011, W0}));
    @(posedge clk); #1;
    tgt_ready = 1'b0;

`ifdef LADYBIRD_ARB_TIMEOUT_EN
    hit = 0; hit_rsv = '0; hit_err = 1'b0; hit_data = '1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        hit = k; hit_rsv = rsp_valid; hit_err = rsp_err; hit_data = rsp_data;
        break;
      end
      @(posedge clk); #1;
    end
    check("timeout wait cycle", 64'(hit), 64'(TMO));
    check("timeout rsp_valid/err", 64'({hit_rsv, hit_err}), 64'({2'b01, 1'b1}));
    check("timeout rsp_data", 64'(hit_data), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy after timeout", 64'(busy), 64'h0);
`else
    stuck = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && rsp_valid === 2'b00) stuck++;
      @(posedge clk); #1;
    end
    check("no-watchdog busy held", 64'(stuck), 64'd40);
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    check("busy after reset", 64'(busy), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
